// File: rtl/data_source_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_source_gen                                              |
// | Description : Burst source of address/data beats with four data patterns   |
// |               and a valid/ready handshake. DS_CHECKSUM_EN adds csum_out.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_source_gen #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 'hC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] len,
  input  logic              ready,
  output logic              valid_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
`ifdef DS_CHECKSUM_EN
  output logic              abort,
  output logic [DATA_W-1:0] csum_out
`else
  output logic              abort
`endif
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  localparam logic [1:0] c_mode_cnt  = 2'd0;
  localparam logic [1:0] c_mode_inv  = 2'd1;
  localparam logic [1:0] c_mode_lfsr = 2'd2;
  localparam logic [1:0] c_mode_walk = 2'd3;

  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
  localparam logic [DATA_W-1:0] c_data_one = DATA_W'(1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;

  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_abort;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_seed;
  logic [ADDR_W-1:0] r_len;

  logic              w_valid_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_abort_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic [1:0]        w_mode_nxt;
  logic [DATA_W-1:0] w_seed_nxt;
  logic [ADDR_W-1:0] w_len_nxt;

  logic              w_xfer;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr_inc;

  // len==0 wraps to all-ones here, which is exactly the 2^ADDR_W-beat case.
  assign w_xfer     = r_valid & ready;
  assign w_last     = (r_addr == (r_len - c_addr_one));
  assign w_addr_inc = r_addr + c_addr_one;

  function automatic logic [DATA_W-1:0] f_first(input logic [1:0]        m,
                                                 input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] v;
    v = s;
    case (m)
      c_mode_cnt:  v = s;
      c_mode_inv:  v = DATA_W'(~{ADDR_W{1'b0}});
      c_mode_lfsr: v = (s == '0) ? c_data_one : s;
      c_mode_walk: v = c_data_one;
      default:     v = s;
    endcase
    return v;
  endfunction

  // LFSR and walking-one step from the current beat; the other modes derive from the new address.
  function automatic logic [DATA_W-1:0] f_next(input logic [1:0]        m,
                                                input logic [DATA_W-1:0] s,
                                                input logic [DATA_W-1:0] d,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = d;
    case (m)
      c_mode_cnt:  v = s + DATA_W'(a);
      c_mode_inv:  v = DATA_W'(~a);
      c_mode_lfsr: v = (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
      c_mode_walk: v = {d[DATA_W-2:0], d[DATA_W-1]};
      default:     v = d;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_state_nxt = c_st_run;
        end
      end
      c_st_run: begin
        if (stop || (w_xfer && w_last)) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_mode_nxt  = r_mode;
    w_seed_nxt  = r_seed;
    w_len_nxt   = r_len;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_addr_nxt  = '0;
          w_data_nxt  = f_first(mode, seed);
          w_mode_nxt  = mode;
          w_seed_nxt  = seed;
          w_len_nxt   = len;
        end
      end
      c_st_run: begin
        if (stop) begin
          w_abort_nxt = 1'b1;
        end else if (w_xfer && w_last) begin
          w_done_nxt = 1'b1;
        end else begin
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          if (w_xfer) begin
            w_addr_nxt = w_addr_inc;
            w_data_nxt = f_next(r_mode, r_seed, r_data, w_addr_inc);
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_mode  <= '0;
      r_seed  <= '0;
      r_len   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_mode  <= w_mode_nxt;
      r_seed  <= w_seed_nxt;
      r_len   <= w_len_nxt;
    end
  end

  assign valid_out = r_valid;
  assign addr_out  = r_addr;
  assign data_out  = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign abort     = r_abort;

`ifdef DS_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  // A beat accepted in the stop cycle still reached the sink, so it is folded in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= '0;
    end else if ((r_state == c_st_idle) && start) begin
      r_csum <= '0;
    end else if ((r_state == c_st_run) && w_xfer) begin
      r_csum <= r_csum ^ r_data;
    end
  end

  assign csum_out = r_csum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_source_gen.sv
`default_nettype none
// Scoreboard bench for data_source_gen: stimulus pushes expected beats/events,
// a negedge monitor pops and compares them.
module tb_data_source_gen;

  localparam int AW = 4;
  localparam int DW = 4;

  localparam logic [1:0] K_BEAT  = 2'd0;
  localparam logic [1:0] K_DONE  = 2'd1;
  localparam logic [1:0] K_ABORT = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          csum_en;
    logic [DW-1:0] csum;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic [AW-1:0] len;
  logic          ready;
  logic          valid_out;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          abort;
`ifdef DS_CHECKSUM_EN
  logic [DW-1:0] csum_out;
`endif

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  data_source_gen #(.ADDR_W(AW), .DATA_W(DW), .LFSR_TAPS(4'hC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .seed      (seed),
    .len       (len),
    .ready     (ready),
    .valid_out (valid_out),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
`ifdef DS_CHECKSUM_EN
    .abort     (abort),
    .csum_out  (csum_out)
`else
    .abort     (abort)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
    q.push_back('{kind: K_BEAT, addr: a, data: d, csum_en: 1'b0, csum: '0});
  endtask

  task automatic push_done(input logic ce, input logic [DW-1:0] cs);
    q.push_back('{kind: K_DONE, addr: '0, data: '0, csum_en: ce, csum: cs});
  endtask

  task automatic push_abort();
    q.push_back('{kind: K_ABORT, addr: '0, data: '0, csum_en: 1'b0, csum: '0});
  endtask

  task automatic expect_evt(input logic [1:0] kind);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (kind == K_BEAT) begin
        chk("beat_addr", 32'(addr_out), 32'(e.addr));
        chk("beat_data", 32'(data_out), 32'(e.data));
      end
      if (kind == K_DONE) chk("busy_at_done", 32'(busy), 32'd0);
      if (kind != K_BEAT) chk("valid_at_end", 32'(valid_out), 32'd0);
`ifdef DS_CHECKSUM_EN
      if (e.csum_en) chk("csum_at_done", 32'(csum_out), 32'(e.csum));
`endif
    end
  endtask

  // Monitor: every transfer, done and abort must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out && ready) expect_evt(K_BEAT);
      if (done || abort) chk("done_abort_excl", 32'(done & abort), 32'd0);
      if (done) expect_evt(K_DONE);
      if (abort) expect_evt(K_ABORT);
    end
  end

  task automatic start_burst(input logic [1:0] m, input logic [DW-1:0] s, input logic [AW-1:0] l);
    start = 1'b1;
    mode  = m;
    seed  = s;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || abort) && (n < budget));
    if (!(done || abort)) begin
      n_chk++;
      n_err++;
      $display("FAIL burst_timeout: got no done/abort expected one within %0d cycles", budget);
    end
  endtask

  logic [DW-1:0] lfsr_exp [16];
  logic          rdy_pat  [5];

  initial begin
    lfsr_exp = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
    rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0; seed = '0; len = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_abort", 32'(abort),     32'd0);
    chk("rst_addr",  32'(addr_out),  32'd0);
    chk("rst_data",  32'(data_out),  32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Counter pattern, seed 3, four beats; first beat one cycle after start.
    ready = 1'b1;
    push_beat(4'd0, 4'd3); push_beat(4'd1, 4'd4); push_beat(4'd2, 4'd5); push_beat(4'd3, 4'd6);
    push_done(1'b0, '0);
    start_burst(2'd0, 4'd3, 4'd4);
    @(negedge clk);
    chk("first_valid", 32'(valid_out), 32'd1);
    chk("first_busy",  32'(busy),      32'd1);
    wait_end(20);

    // Inverted address; restarted in the done cycle.
    push_beat(4'd0, 4'hF); push_beat(4'd1, 4'hE);
    push_done(1'b0, '0);
    start_burst(2'd1, 4'd9, 4'd2);
    wait_end(10);

    // LFSR, len 0 means the full 16 beats.
    for (int i = 0; i < 16; i++) push_beat(4'(i), lfsr_exp[i]);
    push_done(1'b0, '0);
    start_burst(2'd2, 4'd1, 4'd0);
    wait_end(40);

    // Back-pressure: beat 1 must be held through two not-ready cycles.
    push_beat(4'd0, 4'd5); push_beat(4'd1, 4'd6); push_beat(4'd2, 4'd7);
    push_done(1'b0, '0);
    start_burst(2'd0, 4'd5, 4'd3);
    for (int i = 0; i < 5; i++) begin
      ready = rdy_pat[i];
      @(negedge clk);
      if (!rdy_pat[i]) begin
        chk("hold_addr", 32'(addr_out), 32'd1);
        chk("hold_data", 32'(data_out), 32'd6);
      end
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    wait_end(10);

    // Stop on beat 2 of 8: that beat is accepted, then abort with no done.
    push_beat(4'd0, 4'd0); push_beat(4'd1, 4'd1); push_beat(4'd2, 4'd2);
    push_abort();
    start_burst(2'd0, 4'd0, 4'd8);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    @(negedge clk);
    chk("abort_pulse",  32'(abort),     32'd1);
    chk("abort_valid",  32'(valid_out), 32'd0);
    chk("abort_busy",   32'(busy),      32'd0);

    // start with stop in IDLE: start wins, burst restarts from address 0.
    push_beat(4'd0, 4'd7); push_beat(4'd1, 4'd8);
    push_done(1'b0, '0);
    stop = 1'b1;
    start_burst(2'd0, 4'd7, 4'd2);
    stop = 1'b0;
    wait_end(10);

    // Asynchronous reset between edges while beat 2 is presented.
    push_beat(4'd0, 4'd2); push_beat(4'd1, 4'd3);
    start_burst(2'd0, 4'd2, 4'd8);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_busy",  32'(busy),      32'd0);
    chk("arst_addr",  32'(addr_out),  32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_done",  32'(done),  32'd0);
    chk("post_rst_abort", 32'(abort), 32'd0);

    // Walking one.
    push_beat(4'd0, 4'd1); push_beat(4'd1, 4'd2); push_beat(4'd2, 4'd4); push_beat(4'd3, 4'd8);
    push_done(1'b0, '0);
    start_burst(2'd3, 4'd0, 4'd4);
    wait_end(10);

`ifdef DS_CHECKSUM_EN
    for (int i = 0; i < 4; i++) push_beat(4'(i), 4'(i));
    push_done(1'b1, 4'd0);
    start_burst(2'd0, 4'd0, 4'd4);
    wait_end(10);

    for (int i = 0; i < 4; i++) push_beat(4'(i), 4'(i + 1));
    push_done(1'b1, 4'd4);
    start_burst(2'd0, 4'd1, 4'd4);
    @(negedge clk);
    chk("csum_cleared", 32'(csum_out), 32'd0);
    wait_end(10);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1);
  end

endmodule
`default_nettype wire
